gauss_window_ctrl: RTL and testbench

- Frame sequencer for the 3x3 Gaussian smoothing datapath.
- Tracks input field/line timing and produces the kernel-centre valid, the pixel/line position and the four border flags.
- Latches the coefficient set once per frame and generates a synthetic flush line after each frame, so the last image row is filtered.
- Sits between the Y16 video source and the multiply/normalise datapath; flags errors to the register block.

---
 rtl/gauss_window_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_gauss_window_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_window_ctrl.sv
// gauss_window_ctrl: frame sequencer for the 3x3 Gaussian smoothing datapath.
// Tracks field/line timing of the Y16 source, produces the kernel-centre valid
// with its pixel/line position and border flags, latches the kernel weights
// once per frame and appends a synthetic flush line so the last row is filtered.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_field_vld             frame valid, high across all active lines
//   i_line_vld              line valid, high for each active pixel
//   i_gauss_level           kernel select, sampled at frame start only
//   o_win_vld               kernel centre valid (datapath enable)
//   o_pix_cnt, o_line_cnt   centre column / row
//   o_top/o_bot/o_left/o_right  centre on a frame border (valid with o_win_vld)
//   o_coef_corner/edge/center, o_coef_sum  active weights and divisor
//   o_frame_done            one-cycle pulse after the last centre pixel
//   o_err_len/lines/ovr     sticky errors, cleared at the next frame start
module gauss_window_ctrl #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 512,
  parameter int unsigned CNT_DW    = 16,
  parameter int unsigned FLUSH_GAP = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_field_vld,
  input  logic              i_line_vld,
  input  logic [2:0]        i_gauss_level,
  output logic              o_win_vld,
  output logic [CNT_DW-1:0] o_pix_cnt,
  output logic [CNT_DW-1:0] o_line_cnt,
  output logic              o_top,
  output logic              o_bot,
  output logic              o_left,
  output logic              o_right,
  output logic [10:0]       o_coef_corner,
  output logic [10:0]       o_coef_edge,
  output logic [10:0]       o_coef_center,
  output logic [18:0]       o_coef_sum,
  output logic              o_frame_done,
  output logic              o_err_len,
  output logic              o_err_lines,
  output logic              o_err_ovr
);

  localparam int unsigned CW = 11;
  localparam int unsigned SW = 19;

  localparam logic [CNT_DW-1:0] ONE      = CNT_DW'(1);
  localparam logic [CNT_DW-1:0] W_FULL   = CNT_DW'(IMG_W);
  localparam logic [CNT_DW-1:0] W_LAST   = CNT_DW'(IMG_W - 1);
  localparam logic [CNT_DW-1:0] H_FULL   = CNT_DW'(IMG_H);
  localparam logic [CNT_DW-1:0] H_LAST   = CNT_DW'(IMG_H - 1);
  localparam logic [CNT_DW-1:0] GAP_LAST = CNT_DW'(FLUSH_GAP - 1);

  localparam logic [CW-1:0] L0_CORNER = CW'(298);
  localparam logic [CW-1:0] L0_EDGE   = CW'(552);
  localparam logic [CW-1:0] L0_CENTER = CW'(1024);
  localparam logic [SW-1:0] L0_SUM    = SW'(4424);
  localparam logic [CW-1:0] L1_CORNER = CW'(377);
  localparam logic [CW-1:0] L1_EDGE   = CW'(621);
  localparam logic [CW-1:0] L1_CENTER = CW'(1024);
  localparam logic [SW-1:0] L1_SUM    = SW'(5016);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_GAP, S_FLUSH, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_field_d;
  logic              r_line_d;
  logic [CNT_DW-1:0] r_in_pix;
  logic [CNT_DW-1:0] r_in_line;
  logic [CNT_DW-1:0] r_gap_cnt;

  logic              w_line_in;
  logic              w_field_rise;
  logic              w_field_fall;
  logic              w_line_fall;
  logic              w_start_ovr;
  logic              w_start;
  logic              w_len_bad;
  logic [CNT_DW-1:0] w_row_idx;

  // Line activity outside the field is ignored entirely.
  assign w_line_in    = i_line_vld & i_field_vld;
  assign w_field_rise = i_field_vld & ~r_field_d;
  assign w_field_fall = ~i_field_vld & r_field_d;
  assign w_line_fall  = ~w_line_in & r_line_d;
  assign w_len_bad    = (r_in_pix != W_FULL);

  // A new frame is accepted from IDLE/DONE; arriving in GAP/FLUSH is an overrun.
  assign w_start_ovr = w_field_rise & ((r_state == S_GAP) | (r_state == S_FLUSH));
  assign w_start     = w_start_ovr |
                       (w_field_rise & ((r_state == S_IDLE) | (r_state == S_DONE)));

  // Centre row lags the input row by one; extra input rows pin it to the last row.
  assign w_row_idx = (r_in_line >= H_FULL) ? H_LAST : (r_in_line - ONE);

  // Border flags qualified by the centre valid.
  assign o_left  = o_win_vld & (o_pix_cnt == '0);
  assign o_right = o_win_vld & (o_pix_cnt == W_LAST);
  assign o_top   = o_win_vld & (o_line_cnt == '0);
  assign o_bot   = o_win_vld & (o_line_cnt == H_LAST);

  // Input edge history and per-line pixel count (saturating).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_field_d <= 1'b0;
      r_line_d  <= 1'b0;
      r_in_pix  <= '0;
    end else begin
      r_field_d <= i_field_vld;
      r_line_d  <= w_line_in;
      if (w_line_fall || w_field_rise) begin
        r_in_pix <= w_line_in ? ONE : '0;
      end else if (w_line_in && !(&r_in_pix)) begin
        r_in_pix <= r_in_pix + ONE;
      end
    end
  end

  // Kernel weights, latched at frame start; unknown levels keep the current set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_coef_corner <= L0_CORNER;
      o_coef_edge   <= L0_EDGE;
      o_coef_center <= L0_CENTER;
      o_coef_sum    <= L0_SUM;
    end else if (w_start) begin
      case (i_gauss_level)
        3'd0: begin
          o_coef_corner <= L0_CORNER;
          o_coef_edge   <= L0_EDGE;
          o_coef_center <= L0_CENTER;
          o_coef_sum    <= L0_SUM;
        end
        3'd1: begin
          o_coef_corner <= L1_CORNER;
          o_coef_edge   <= L1_EDGE;
          o_coef_center <= L1_CENTER;
          o_coef_sum    <= L1_SUM;
        end
        default: ;
      endcase
    end
  end

  // Frame sequencer with registered window outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_in_line    <= '0;
      r_gap_cnt    <= '0;
      o_win_vld    <= 1'b0;
      o_pix_cnt    <= '0;
      o_line_cnt   <= '0;
      o_frame_done <= 1'b0;
      o_err_len    <= 1'b0;
      o_err_lines  <= 1'b0;
      o_err_ovr    <= 1'b0;
    end else begin
      o_win_vld    <= 1'b0;
      o_pix_cnt    <= '0;
      o_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: ;
        S_PRIME: begin
          if (w_line_fall && w_len_bad) o_err_len <= 1'b1;
          if (w_field_fall) begin
            o_err_lines <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_line_fall) begin
            r_in_line <= r_in_line + ONE;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          o_win_vld  <= w_line_in;
          o_line_cnt <= w_row_idx;
          if (w_line_in && o_win_vld) begin
            o_pix_cnt <= (o_pix_cnt == W_LAST) ? W_LAST : (o_pix_cnt + ONE);
          end
          if (w_line_fall) begin
            if (w_len_bad) o_err_len <= 1'b1;
            if (!(&r_in_line)) r_in_line <= r_in_line + ONE;
          end
          if (w_field_fall) begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          // First GAP cycle sees the final line count, including a coincident last line_fall.
          if ((r_gap_cnt == '0) && (r_in_line != H_FULL)) o_err_lines <= 1'b1;
          if (r_gap_cnt == GAP_LAST) begin
            o_win_vld  <= 1'b1;
            o_line_cnt <= H_LAST;
            r_state    <= S_FLUSH;
          end else begin
            r_gap_cnt <= r_gap_cnt + ONE;
          end
        end
        S_FLUSH: begin
          // o_pix_cnt doubles as the flush length counter.
          if (o_pix_cnt == W_LAST) begin
            o_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            o_win_vld <= 1'b1;
            o_pix_cnt <= o_pix_cnt + ONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Frame start overrides whatever the current state decided.
      if (w_start) begin
        r_state      <= S_PRIME;
        r_in_line    <= '0;
        o_win_vld    <= 1'b0;
        o_pix_cnt    <= '0;
        o_frame_done <= 1'b0;
        o_err_len    <= 1'b0;
        o_err_lines  <= 1'b0;
        o_err_ovr    <= w_start_ovr;
      end
    end
  end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Testbench for gauss_window_ctrl: frame table plus reset and overrun sequences,
// with a scoreboard of expected centre pixels and frame_done pulses.
module tb_gauss_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int G  = 4;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          field = 1'b0;
  logic          line  = 1'b0;
  logic [2:0]    lvl   = 3'd0;

  logic          o_win_vld;
  logic [DW-1:0] o_pix_cnt;
  logic [DW-1:0] o_line_cnt;
  logic          o_top, o_bot, o_left, o_right;
  logic [10:0]   o_coef_corner, o_coef_edge, o_coef_center;
  logic [18:0]   o_coef_sum;
  logic          o_frame_done, o_err_len, o_err_lines, o_err_ovr;

  gauss_window_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_DW(DW), .FLUSH_GAP(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_field_vld(field), .i_line_vld(line),
    .i_gauss_level(lvl), .o_win_vld(o_win_vld), .o_pix_cnt(o_pix_cnt),
    .o_line_cnt(o_line_cnt), .o_top(o_top), .o_bot(o_bot), .o_left(o_left),
    .o_right(o_right), .o_coef_corner(o_coef_corner), .o_coef_edge(o_coef_edge),
    .o_coef_center(o_coef_center), .o_coef_sum(o_coef_sum),
    .o_frame_done(o_frame_done), .o_err_len(o_err_len),
    .o_err_lines(o_err_lines), .o_err_ovr(o_err_ovr)
  );

  always #5 clk = ~clk;

  typedef struct { int pix; int ln; int cyc; int cset; } win_t;
  typedef struct {
    int nlines; int short_row; int short_w; int level; int level_mid;
    int abort; int started; int e_len; int e_lines; int e_ovr;
  } frame_t;

  win_t win_q[$];
  int   done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mset     = 0;
  int   cor_t[2] = '{298, 377};
  int   edg_t[2] = '{552, 621};
  int   sum_t[2] = '{4424, 5016};

  logic [63:0] act_coef;
  logic [63:0] act_out;
  assign act_coef = {12'd0, o_coef_corner, o_coef_edge, o_coef_center, o_coef_sum};
  assign act_out  = 64'({o_win_vld, o_pix_cnt, o_line_cnt, o_top, o_bot, o_left, o_right,
                         o_frame_done, o_err_len, o_err_lines, o_err_ovr});

  function automatic logic [63:0] coef_vec(input int s);
    return {12'd0, 11'(cor_t[s]), 11'(edg_t[s]), 11'd1024, 19'(sum_t[s])};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic latch(input logic [2:0] lv);
    if (lv == 3'd0) mset = 0;
    else if (lv == 3'd1) mset = 1;
  endtask

  task automatic push_win(input int pix, input int ln, input int c);
    win_t e;
    e.pix = pix; e.ln = ln; e.cyc = c; e.cset = mset;
    win_q.push_back(e);
  endtask

  // One clock: advance to the falling edge and score any DUT output seen there.
  task automatic tick();
    win_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (o_win_vld) begin
        if (win_q.size() == 0) begin
          chk("win_unexpected", 64'(o_win_vld), 64'd0);
        end else begin
          e = win_q.pop_front();
          chk("win_cycle", 64'(cyc), 64'(e.cyc));
          chk("win_pos", {28'd0, o_pix_cnt, o_line_cnt, o_top, o_bot, o_left, o_right},
              {28'd0, 16'(e.pix), 16'(e.ln), e.ln == 0, e.ln == H - 1, e.pix == 0, e.pix == W - 1});
          chk("win_coef", act_coef, coef_vec(e.cset));
        end
      end
      if (o_frame_done) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(o_frame_done), 64'd0);
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((win_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (win_q.size() != 0 || done_q.size() != 0) begin
      chk("drain_timeout", 64'(win_q.size() + done_q.size()), 64'd0);
      win_q.delete();
      done_q.delete();
    end
  endtask

  // Drive one frame (3-cycle h-blank) and queue the centre pixels it must yield.
  task automatic drive_frame(input frame_t f);
    int fall_c;
    int w;
    if (f.started == 0) begin
      tick(); lvl = 3'(f.level); field = 1'b1; latch(lvl);
    end
    tick(); tick();
    for (int r = 0; r < f.nlines; r++) begin
      if (r == 2) lvl = 3'(f.level_mid);
      w = (r == f.short_row) ? f.short_w : W;
      for (int p = 0; p < w; p++) begin
        tick(); line = 1'b1;
        if (r >= 1) push_win((p < W) ? p : W - 1, (r - 1 < H) ? r - 1 : H - 1, cyc + 1);
      end
      tick(); line = 1'b0;
      if (f.nlines == 1) field = 1'b0;
      else begin tick(); tick(); end
    end
    if (f.nlines == 1) begin
      repeat (G + W + 6) tick();
    end else begin
      tick(); field = 1'b0; fall_c = cyc;
      if (f.abort != 0) begin
        for (int i = 0; i < 2; i++) push_win(i, H - 1, fall_c + 1 + G + i);
        while (cyc < fall_c + 2 + G) tick();
        field = 1'b1; latch(lvl);
      end else begin
        for (int i = 0; i < W; i++) push_win(i, H - 1, fall_c + 1 + G + i);
        done_q.push_back(fall_c + G + W + 1);
        wait_drain();
      end
    end
  endtask

  initial begin
    frame_t tbl[13];
    frame_t fr;
    //          lines srow sw lvl mid abt st len lns ovr
    tbl[0]  = '{4, -1, 8, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{4, -1, 8, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{4, -1, 8, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{4, -1, 8, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{4, -1, 8, 5, 5, 0, 0, 0, 0, 0};
    tbl[5]  = '{4,  2, 7, 0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{3, -1, 8, 0, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{6, -1, 8, 0, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{1, -1, 8, 0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{4, -1, 8, 1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{4, -1, 8, 1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{4, -1, 8, 0, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{4, -1, 8, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) tick();
    chk("reset_outputs", act_out, 64'd0);
    chk("reset_coef", act_coef, coef_vec(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive_frame(tbl[i]);
      if (tbl[i].abort != 0) begin
        tick();
        chk("ovr_abort", {62'd0, o_err_ovr, o_win_vld}, 64'd2);
      end else begin
        chk($sformatf("err_flags_f%0d", i), {61'd0, o_err_len, o_err_lines, o_err_ovr},
            64'({tbl[i].e_len[0], tbl[i].e_lines[0], tbl[i].e_ovr[0]}));
      end
    end

    // Reset asserted while row 1 is producing centre pixels.
    tick(); lvl = 3'd1; field = 1'b1; latch(lvl);
    tick(); tick();
    for (int p = 0; p < W; p++) begin tick(); line = 1'b1; end
    tick(); line = 1'b0; tick(); tick();
    for (int p = 0; p < 4; p++) begin tick(); line = 1'b1; push_win(p, 0, cyc + 1); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", act_out, 64'd0);
    chk("midrun_reset_coef", act_coef, coef_vec(0));
    mset = 0;
    win_q.delete();
    done_q.delete();
    field = 1'b0; line = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    fr = '{4, -1, 8, 5, 5, 0, 0, 0, 0, 0};
    drive_frame(fr);
    chk("after_reset_flags", {61'd0, o_err_len, o_err_lines, o_err_ovr}, 64'd0);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
